pc_seq_unit: RTL and testbench

Registered, parametrised program counter for the pipelined core's fetch stage. Replaces the combinational PC select with a clocked PC and the following controls:
- Redirect on branch or hazard.
- Multi-cycle flush window.
- Stall hold.
- Halt.

pc_out drives the instruction-memory address. flush_out drives the IF/ID and ID/EX bubble insertion.

---
 rtl/pc_seq_unit.sv | 122 ++++++++++++
 tb/tb_pc_seq_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Registered fetch-stage program counter with redirect, timed flush window, stall hold and sticky halt.
// pc_plus is the only combinational output.
module pc_seq_unit #(
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                PC_INC    = 1,
    parameter int                FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redir_addr,
    input  logic              halt_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              fetch_valid,
    output logic              flush_out,
    output logic              halted
);

    localparam int                CNT_W        = 4;
    localparam logic [ADDR_W-1:0] INC          = ADDR_W'(PC_INC);
    localparam logic [CNT_W-1:0]  FLUSH_RELOAD = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              flush_q, flush_d;
    logic              halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VEC;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            halted_q      <= halted_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        halted_d      = halted_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                pc_d          = RESET_VEC;
                cnt_d         = '0;
                fetch_valid_d = 1'b1;
                halted_d      = 1'b0;
            end
            ST_RUN, ST_FLUSH: begin
                fetch_valid_d = 1'b1;
                halted_d      = 1'b0;
                if (halt_in) begin
                    state_d       = ST_HALT;
                    cnt_d         = '0;
                    fetch_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (redirect_in) begin
                    // Reloading here restarts an in-progress window with no gap in flush_out.
                    pc_d    = redir_addr;
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_RELOAD;
                    state_d = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
                end else begin
                    if (!stall_in) begin
                        pc_d = pc_q + INC;
                    end
                    if (state_q == ST_FLUSH && cnt_q != '0) begin
                        flush_d = 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                cnt_d         = '0;
                fetch_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: begin
                state_d       = ST_BOOT;
                pc_d          = RESET_VEC;
                cnt_d         = '0;
                fetch_valid_d = 1'b0;
                halted_d      = 1'b0;
            end
        endcase
    end

    assign pc_out      = pc_q;
    assign pc_plus     = pc_q + INC;
    assign fetch_valid = fetch_valid_q;
    assign flush_out   = flush_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed vector table, two hand sequences, then random traffic
// checked against a cycle-level behavioural model.
module tb_pc_seq_unit;

    localparam int         AW    = 6;
    localparam logic [5:0] RV    = 6'd4;
    localparam int         INC   = 1;
    localparam int         NFL   = 2;
    localparam int         PMOD  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall_in = 1'b0;
    logic       redirect_in = 1'b0;
    logic       halt_in = 1'b0;
    logic [5:0] redir_addr = 6'd0;
    logic [5:0] pc_out;
    logic [5:0] pc_plus;
    logic       fetch_valid;
    logic       flush_out;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model: flush expressed as "pulse cycles still owed" after the current one.
    int m_pc = RV;
    bit m_fv = 1'b0;
    bit m_fl = 1'b0;
    bit m_hl = 1'b0;
    bit m_boot = 1'b1;
    int m_owed = 0;

    typedef struct {
        bit         r;
        bit         s;
        bit         d;
        bit         h;
        logic [5:0] a;
        int         pc;
        bit         fv;
        bit         fl;
        bit         hl;
    } vec_t;

    vec_t tbl[$];

    pc_seq_unit #(
        .ADDR_W   (AW),
        .RESET_VEC(RV),
        .PC_INC   (INC),
        .FLUSH_CYC(NFL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_in   (stall_in),
        .redirect_in(redirect_in),
        .redir_addr (redir_addr),
        .halt_in    (halt_in),
        .pc_out     (pc_out),
        .pc_plus    (pc_plus),
        .fetch_valid(fetch_valid),
        .flush_out  (flush_out),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit d, input logic [5:0] a, input bit h);
        rst_n       = r;
        stall_in    = s;
        redirect_in = d;
        redir_addr  = a;
        halt_in     = h;
    endtask

    task automatic modelStep();
        if (!rst_n) begin
            m_pc = RV; m_fv = 0; m_fl = 0; m_hl = 0; m_boot = 1; m_owed = 0;
        end else if (m_boot) begin
            m_boot = 0; m_fv = 1;
        end else if (m_hl) begin
            m_fl = 0;
        end else if (halt_in) begin
            m_hl = 1; m_fv = 0; m_fl = 0; m_owed = 0;
        end else if (redirect_in) begin
            m_pc = int'(redir_addr); m_fl = 1; m_owed = NFL - 1;
        end else begin
            if (!stall_in) m_pc = (m_pc + INC) % PMOD;
            if (m_owed > 0) begin
                m_fl = 1; m_owed--;
            end else begin
                m_fl = 0;
            end
        end
    endtask

    task automatic tickEdge();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic expectAll(input string tag, input int pc, input bit fv, input bit fl, input bit hl);
        checkOutput({tag, ".pc_out"}, int'(pc_out), pc);
        checkOutput({tag, ".pc_plus"}, int'(pc_plus), (pc + INC) % PMOD);
        checkOutput({tag, ".fetch_valid"}, int'(fetch_valid), int'(fv));
        checkOutput({tag, ".flush_out"}, int'(flush_out), int'(fl));
        checkOutput({tag, ".halted"}, int'(halted), int'(hl));
    endtask

    function automatic vec_t mk(bit r, bit s, bit d, bit h, logic [5:0] a, int pc, bit fv, bit fl, bit hl);
        vec_t v;
        v.r = r; v.s = s; v.d = d; v.h = h; v.a = a;
        v.pc = pc; v.fv = fv; v.fl = fl; v.hl = hl;
        return v;
    endfunction

    initial begin
        // Rows: inputs before the edge, expected registered outputs after it.
        tbl.push_back(mk(0,0,0,0, 6'd0,   4, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 6'd0,   4, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,   4, 1, 0, 0));
        for (int p = 5; p <= 10; p++) tbl.push_back(mk(1,0,0,0, 6'd0, p, 1, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,0,0, 6'd0, 10, 1, 0, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,  11, 1, 0, 0));
        tbl.push_back(mk(1,1,1,0, 6'd40, 40, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,  41, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,  42, 1, 0, 0));
        tbl.push_back(mk(1,0,1,0, 6'd20, 20, 1, 1, 0));
        tbl.push_back(mk(1,0,1,0, 6'd50, 50, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,  51, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,  52, 1, 0, 0));
        tbl.push_back(mk(1,0,1,0, 6'd62, 62, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,  63, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,   0, 1, 0, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,   1, 1, 0, 0));
        tbl.push_back(mk(1,0,1,0, 6'd30, 30, 1, 1, 0));
        tbl.push_back(mk(1,0,0,1, 6'd0,  30, 0, 0, 1));
        tbl.push_back(mk(1,0,1,0, 6'd5,  30, 0, 0, 1));
        tbl.push_back(mk(1,1,0,0, 6'd0,  30, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0, 6'd0,   4, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,   4, 1, 0, 0));
        tbl.push_back(mk(1,0,0,0, 6'd0,   5, 1, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].a, tbl[i].h);
            tickEdge();
            expectAll($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].hl);
        end

        // Reset in the middle of a flush window, then control inputs during BOOT are ignored.
        applyStimulus(1, 0, 1, 6'd33, 0); tickEdge(); expectAll("rstflush.redir", 33, 1, 1, 0);
        applyStimulus(0, 0, 0, 6'd0, 0);  tickEdge(); expectAll("rstflush.rst", 4, 0, 0, 0);
        applyStimulus(1, 1, 1, 6'd9, 1);  tickEdge(); expectAll("rstflush.boot", 4, 1, 0, 0);
        applyStimulus(1, 0, 0, 6'd0, 0);  tickEdge(); expectAll("rstflush.run", 5, 1, 0, 0);

        // Halt beats stall while flushing, and stays put afterwards.
        applyStimulus(1, 0, 1, 6'd12, 0); tickEdge(); expectAll("haltflush.redir", 12, 1, 1, 0);
        applyStimulus(1, 1, 0, 6'd0, 1);  tickEdge(); expectAll("haltflush.halt", 12, 0, 0, 1);
        applyStimulus(1, 0, 0, 6'd0, 0);  tickEdge(); expectAll("haltflush.hold", 12, 0, 0, 1);

        // Random traffic against the model; the first cycle resets to synchronise both.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(i != 0 && $urandom_range(0, 63) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0,
                          6'($urandom),
                          $urandom_range(0, 39) == 0);
            tickEdge();
            expectAll($sformatf("rnd%0d", i), m_pc, m_fv, m_fl, m_hl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
